// File: rtl/adler32_feeder_pkg.sv
// Shared definitions for the Adler-32 front end: feeder FSM states and the
// word/modulus constants also used by the checksum engine.
package adler32_feeder_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned ADLER_MOD      = 65521;

    typedef enum logic [2:0] {
        IDLE,
        SIZE,
        FILL,
        START,
        STREAM,
        WAIT_CK
    } feeder_state_t;

endpackage

// File: rtl/adler32_feeder_fifo.sv
// Synchronous word FIFO with occupancy count; head word is visible combinationally.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clock,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/adler32_feeder.sv
// Front end for the Adler-32 engine: takes a byte-length descriptor and a word
// stream, buffers words, and serialises them as a gap-free little-endian byte stream.
module adler32_feeder
    import adler32_feeder_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned THRESH = 4
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        in_len_valid,
    input  logic [31:0] in_len,
    output logic        in_len_ready,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    input  logic        checksum_valid,
    output logic        size_valid,
    output logic [31:0] size,
    output logic        data_start,
    output logic [7:0]  data,
    output logic        busy,
    output logic        underrun
);

    localparam int unsigned CW = $clog2(DEPTH+1);

    feeder_state_t state, next_state;

    logic [32:0]   total_words;
    logic [32:0]   total_words_q;
    logic [32:0]   words_left_in;
    logic [32:0]   fill_target;
    logic [31:0]   bytes_left;
    logic [1:0]    byte_idx;
    logic [31:0]   fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          len_hs;
    logic          push;
    logic          pop;
    logic          consume;

    assign total_words  = ({1'b0, in_len} + 33'd3) >> 2;
    assign fill_target  = (total_words_q < 33'(THRESH)) ? total_words_q : 33'(THRESH);
    assign in_len_ready = (state == IDLE);
    assign len_hs       = in_len_valid && in_len_ready;
    assign in_ready     = (state != IDLE) && !fifo_full && (words_left_in != '0);
    assign push         = in_valid && in_ready;

    // The byte shown in a STREAM cycle is picked one cycle earlier (START or the
    // previous STREAM cycle) so that data can leave straight from a flop.
    assign consume = ((state == START) || (state == STREAM)) && (bytes_left != '0);
    assign pop     = consume && !fifo_empty
                     && ((byte_idx == 2'(BYTES_PER_WORD-1)) || (bytes_left == 32'd1));

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .rst       (rst),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (len_hs) next_state = SIZE;
            SIZE:    next_state = FILL;
            FILL:    if (33'(fifo_count) >= fill_target) next_state = START;
            START:   next_state = (bytes_left == '0) ? WAIT_CK : STREAM;
            STREAM:  if (bytes_left == '0) next_state = WAIT_CK;
            WAIT_CK: if (checksum_valid) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state         <= IDLE;
            total_words_q <= '0;
            words_left_in <= '0;
            bytes_left    <= '0;
            byte_idx      <= '0;
            size_valid    <= 1'b0;
            size          <= '0;
            data_start    <= 1'b0;
            data          <= '0;
            busy          <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            state      <= next_state;
            size_valid <= (next_state == SIZE);
            data_start <= (next_state == START);
            busy       <= (next_state != IDLE);
            if (len_hs) begin
                total_words_q <= total_words;
                words_left_in <= total_words;
                bytes_left    <= in_len;
                byte_idx      <= '0;
                size          <= in_len;
                underrun      <= 1'b0;
            end else if (push) begin
                words_left_in <= words_left_in - 33'd1;
            end
            if (consume) begin
                data       <= fifo_empty ? 8'h00 : fifo_head[{byte_idx, 3'b000} +: 8];
                bytes_left <= bytes_left - 32'd1;
                byte_idx   <= byte_idx + 2'd1;
                if (fifo_empty) underrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adler32_feeder.sv
// Self-checking bench for adler32_feeder: a cycle-level queue model checks every
// output each cycle; directed messages pin the model with literal expectations.
`timescale 1ns/1ps
module tb_adler32_feeder;
    import adler32_feeder_pkg::*;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned THRESH = 4;
    localparam int P_IDLE = 0, P_SIZE = 1, P_FILL = 2, P_START = 3, P_STREAM = 4, P_WAIT = 5;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        in_len_valid = 1'b0;
    logic [31:0] in_len = '0;
    logic        in_len_ready;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        checksum_valid = 1'b0;
    logic        size_valid;
    logic [31:0] size;
    logic        data_start;
    logic [7:0]  data;
    logic        busy;
    logic        underrun;

    adler32_feeder #(.DEPTH(DEPTH), .THRESH(THRESH)) dut (
        .clock          (clock),
        .rst            (rst),
        .in_len_valid   (in_len_valid),
        .in_len         (in_len),
        .in_len_ready   (in_len_ready),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .checksum_valid (checksum_valid),
        .size_valid     (size_valid),
        .size           (size),
        .data_start     (data_start),
        .data           (data),
        .busy           (busy),
        .underrun       (underrun)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] adler(input logic [7:0] b[$]);
        int unsigned a = 1;
        int unsigned s = 0;
        foreach (b[i]) begin
            a = (a + b[i]) % ADLER_MOD;
            s = (s + a) % ADLER_MOD;
        end
        return {s[15:0], a[15:0]};
    endfunction

    // Behavioural model: words held by the feeder, message progress, next-cycle outputs.
    int          ph = P_IDLE;
    logic [31:0] mq[$];
    longint      m_len = 0, m_left = 0, m_done = 0;
    int          m_idx = 0;
    logic        e_size_valid = 1'b0, e_data_start = 1'b0, e_busy = 1'b0, e_underrun = 1'b0;
    logic [31:0] e_size = '0;
    logic [7:0]  e_data = '0;
    logic [7:0]  got_bytes[$];
    bit          saw_full = 1'b0;

    task take_byte();
        logic [31:0] w;
        if (mq.size() == 0) begin
            e_data     = 8'h00;
            e_underrun = 1'b1;
        end else begin
            w      = mq[0];
            e_data = w[8*m_idx +: 8];
            if (m_idx == 3 || m_done + 1 == m_len) w = mq.pop_front();
        end
        m_idx = (m_idx + 1) % 4;
        m_done++;
    endtask

    always @(negedge clock) begin : compare
        logic exp_in_ready;
        int   nph;
        exp_in_ready = (ph != P_IDLE) && (mq.size() < DEPTH) && (m_left != 0);
        chk("size_valid", size_valid, e_size_valid);
        chk("size", size, e_size);
        chk("data_start", data_start, e_data_start);
        chk("data", data, e_data);
        chk("busy", busy, e_busy);
        chk("underrun", underrun, e_underrun);
        chk("in_len_ready", in_len_ready, ph == P_IDLE);
        chk("in_ready", in_ready, exp_in_ready);
        if (ph == P_STREAM) got_bytes.push_back(data);
        if (ph != P_IDLE && mq.size() == DEPTH) saw_full = 1'b1;

        if (rst) begin
            ph = P_IDLE; mq.delete(); m_len = 0; m_left = 0; m_done = 0; m_idx = 0;
            e_size_valid = 0; e_data_start = 0; e_busy = 0; e_underrun = 0; e_size = '0; e_data = '0;
        end else begin
            nph = ph;
            case (ph)
                P_IDLE: if (in_len_valid) begin
                    m_len = in_len; m_left = (m_len + 3) / 4; m_done = 0; m_idx = 0;
                    e_underrun = 1'b0; e_size = in_len; nph = P_SIZE;
                end
                P_SIZE:   nph = P_FILL;
                P_FILL:   if (mq.size() >= (((m_left + mq.size()) < THRESH) ? (m_left + mq.size()) : THRESH))
                              nph = P_START;
                P_START:  if (m_len == 0) nph = P_WAIT; else begin take_byte(); nph = P_STREAM; end
                P_STREAM: if (m_done == m_len) nph = P_WAIT; else take_byte();
                P_WAIT:   if (checksum_valid) nph = P_IDLE;
                default:  nph = P_IDLE;
            endcase
            if (in_valid && exp_in_ready) begin
                mq.push_back(in_data);
                m_left--;
            end
            e_size_valid = (nph == P_SIZE);
            e_data_start = (nph == P_START);
            e_busy       = (nph != P_IDLE);
            ph = nph;
        end
    end

    // Word source with random valid gaps and an optional stall after a given word.
    logic [31:0] src_q[$];
    int src_rate = 100, src_stall_after = -1, src_stall_len = 0, src_sent = 0, stall_cnt = 0;

    initial begin : source
        bit hs;
        logic [31:0] w;
        forever begin
            @(negedge clock);
            hs = in_valid && in_ready;
            @(posedge clock); #1;
            if (hs && src_q.size() > 0) begin
                w = src_q.pop_front();
                src_sent++;
                if (src_sent == src_stall_after) stall_cnt = src_stall_len;
            end else if (stall_cnt > 0) begin
                stall_cnt--;
            end
            if (stall_cnt == 0 && src_q.size() > 0 && $urandom_range(99) < src_rate) begin
                in_valid = 1'b1; in_data = src_q[0];
            end else begin
                in_valid = 1'b0; in_data = $urandom;
            end
        end
    end

    int ck_delay = 0;
    bit ck_spurious = 1'b0;

    initial begin : ck_driver
        int wait_cnt = 0;
        forever begin
            @(posedge clock); #1;
            if (ph == P_WAIT) begin
                checksum_valid = (wait_cnt >= ck_delay);
                wait_cnt++;
            end else begin
                wait_cnt = 0;
                checksum_valid = ck_spurious && ($urandom_range(19) == 0);
            end
        end
    end

    task automatic start_msg(input logic [31:0] len, input int rate, input int ck_d);
        int n = 0;
        got_bytes.delete();
        src_sent = 0; src_rate = rate; ck_delay = ck_d;
        @(posedge clock); #1;
        in_len = len; in_len_valid = 1'b1;
        @(negedge clock);
        while (!in_len_ready && n < 100) begin @(negedge clock); n++; end
        chk("descriptor accepted", n < 100, 1);
        @(posedge clock); #1;
        in_len_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((ph != P_IDLE || src_q.size() != 0) && n < budget) begin @(posedge clock); n++; end
        chk({name, " finished in budget"}, n < budget, 1);
        repeat (2) @(posedge clock);
    endtask

    task automatic chk_bytes(input string name, input logic [31:0] w[$], input int len);
        logic [31:0] word;
        chk({name, " byte count"}, got_bytes.size(), len);
        for (int i = 0; i < len && i < got_bytes.size(); i++) begin
            word = w[i/4];
            chk({name, " byte"}, got_bytes[i], word[8*(i%4) +: 8]);
        end
    endtask

    initial begin : main
        logic [31:0] w[$];
        int len;
        repeat (3) @(posedge clock);
        #1 rst = 1'b0;

        w = {32'h44434241};
        src_q = w;
        start_msg(4, 100, 2);
        wait_idle("basic", 200);
        chk_bytes("basic", w, 4);
        chk("basic words", src_sent, 1);

        start_msg(0, 100, 0);
        wait_idle("zero", 100);
        chk("zero bytes", got_bytes.size(), 0);
        chk("zero words", src_sent, 0);

        w = {32'h64636261, 32'h00000065};
        src_q = w;
        start_msg(5, 100, 1);
        wait_idle("partial", 200);
        chk_bytes("partial", w, 5);
        chk("partial adler", adler(got_bytes), 32'h05C801F0);

        w.delete();
        for (int i = 0; i < 20; i++) w.push_back($urandom);
        src_q = w; saw_full = 1'b0;
        start_msg(80, 100, 3);
        wait_idle("backpressure", 600);
        chk_bytes("backpressure", w, 80);
        chk("backpressure words", src_sent, 20);
        chk("backpressure fifo filled", saw_full, 1);
        chk("backpressure no underrun", underrun, 0);

        w.delete();
        for (int i = 0; i < 8; i++) w.push_back($urandom | 32'h01010101);
        src_q = w; src_stall_after = 4; src_stall_len = 18;
        start_msg(32, 100, 2);
        wait_idle("underrun", 400);
        src_stall_after = -1;
        chk("underrun byte count", got_bytes.size(), 32);
        if (got_bytes.size() == 32) chk("underrun zero byte", got_bytes[16], 8'h00);
        repeat (5) @(posedge clock);
        #1 chk("underrun sticky", underrun, 1);

        w = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        src_q = w;
        start_msg(16, 100, 0);
        len = 0;
        while (got_bytes.size() < 3 && len < 200) begin @(posedge clock); len++; end
        chk("reset test reached byte 3", len < 200, 1);
        #1 rst = 1'b1; src_q.delete();
        @(posedge clock); #1 rst = 1'b0;
        @(negedge clock);
        chk("post-reset busy", busy, 0);
        chk("post-reset size", size, 0);
        chk("post-reset data", data, 0);
        chk("post-reset in_len_ready", in_len_ready, 1);
        w = {32'hA4A3A2A1};
        src_q = w;
        start_msg(4, 100, 1);
        wait_idle("after reset", 200);
        chk_bytes("after reset", w, 4);

        ck_spurious = 1'b1;
        for (int m = 0; m < 12; m++) begin
            len = $urandom_range(0, 100);
            w.delete();
            for (int i = 0; i < (len + 3) / 4; i++) w.push_back($urandom);
            src_q = w;
            start_msg(len, $urandom_range(60, 100), $urandom_range(0, 4));
            wait_idle("random", 1500);
            chk("random byte count", got_bytes.size(), len);
            repeat ($urandom_range(0, 5)) @(posedge clock);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
